// File: rtl/piece_ctrl_pkg.sv
// Shared constants for the active-piece controller: piece codes, field widths,
// the error cell index, FSM state encodings and the request decode type.
package piece_ctrl_pkg;

    localparam int BITS_PER_BLOCK = 3;
    localparam int X_POS_IN_BITS  = 4;
    localparam int Y_POS_IN_BITS  = 5;
    localparam int BITS_ROT       = 2;
    localparam int BLK_POS        = 8;
    localparam int BLOCK_WIDTH    = 10;
    localparam int BLOCK_HEIGHT   = 20;

    localparam logic [BLK_POS-1:0] ERR_BLK_POS = '1;

    localparam logic [BITS_PER_BLOCK-1:0] PIECE_EMPTY = 3'd0;
    localparam logic [BITS_PER_BLOCK-1:0] PIECE_I     = 3'd1;
    localparam logic [BITS_PER_BLOCK-1:0] PIECE_O     = 3'd2;
    localparam logic [BITS_PER_BLOCK-1:0] PIECE_T     = 3'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READY = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_SPAWN = 3'd3;
    localparam logic [2:0] ST_KICK  = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    typedef enum logic [2:0] {
        REQ_NONE,
        REQ_ROT,
        REQ_LEFT,
        REQ_RIGHT,
        REQ_DOWN
    } req_e;

    function automatic logic [BITS_ROT-1:0] rot_next(input logic [BITS_ROT-1:0] r);
        return r + BITS_ROT'(1);
    endfunction

endpackage

// File: rtl/piece_ctrl_if.sv
// Candidate link between piece_ctrl (master) and the combinational
// block-position calculator (slave).
interface piece_ctrl_if
    import piece_ctrl_pkg::*;
#(
    parameter int XW   = 4,
    parameter int YW   = 5,
    parameter int POSW = 8
);
    logic [BITS_PER_BLOCK-1:0] cand_piece;
    logic [XW-1:0]             cand_x;
    logic [YW-1:0]             cand_y;
    logic [BITS_ROT-1:0]       cand_rot;
    logic [POSW-1:0]           cand_blk_1;
    logic [POSW-1:0]           cand_blk_2;
    logic [POSW-1:0]           cand_blk_3;
    logic [POSW-1:0]           cand_blk_4;
    logic [2:0]                cand_width;
    logic [2:0]                cand_height;

    modport master (
        output cand_piece, cand_x, cand_y, cand_rot,
        input  cand_blk_1, cand_blk_2, cand_blk_3, cand_blk_4,
        input  cand_width, cand_height
    );

    modport slave (
        input  cand_piece, cand_x, cand_y, cand_rot,
        output cand_blk_1, cand_blk_2, cand_blk_3, cand_blk_4,
        output cand_width, cand_height
    );
endinterface

// File: rtl/piece_ctrl_blk_collide.sv
// Combinational legality check of a candidate placement: error indices,
// board extent overflow and overlap with locked cells.
module blk_collide
    import piece_ctrl_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 4,
    parameter int YW      = 5,
    parameter int POSW    = 8
) (
    input  logic [POSW-1:0]        blk_1,
    input  logic [POSW-1:0]        blk_2,
    input  logic [POSW-1:0]        blk_3,
    input  logic [POSW-1:0]        blk_4,
    input  logic [2:0]             width,
    input  logic [2:0]             height,
    input  logic [XW-1:0]          cand_x,
    input  logic [YW-1:0]          cand_y,
    input  logic [BOARD_W*BOARD_H-1:0] board,
    output logic                   legal
);
    localparam int CELLS = BOARD_W * BOARD_H;
    localparam logic [POSW-1:0] ERR = '1;

    // An index past the board is treated like the error code rather than wrapping.
    function automatic logic cell_bad(input logic [POSW-1:0] blk,
                                      input logic [CELLS-1:0] brd);
        if (blk == ERR || int'(blk) >= CELLS)
            return 1'b1;
        return brd[blk];
    endfunction

    logic [XW:0] x_end;
    logic [YW:0] y_end;
    logic        any_bad;
    logic        out_of_box;

    assign x_end = {1'b0, cand_x} + (XW+1)'(width);
    assign y_end = {1'b0, cand_y} + (YW+1)'(height);

    assign out_of_box = (x_end > (XW+1)'(BOARD_W)) || (y_end > (YW+1)'(BOARD_H));

    assign any_bad = cell_bad(blk_1, board) | cell_bad(blk_2, board) |
                     cell_bad(blk_3, board) | cell_bad(blk_4, board);

    assign legal = !any_bad && !out_of_box;

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller: turns requests into calculator candidates, commits
// or rejects them, and locks the piece on a blocked downward move.
// Optional wall kick on rejected rotation: define TETRIS_WALL_KICK_EN.
module piece_ctrl
    import piece_ctrl_pkg::*;
#(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 4,
    parameter int YW      = 5,
    parameter int POSW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spawn,
    input  logic [BITS_PER_BLOCK-1:0]  spawn_piece,
    input  logic                       mv_left,
    input  logic                       mv_right,
    input  logic                       mv_down,
    input  logic                       mv_rot,
    input  logic                       gravity_tick,
    input  logic [BOARD_W*BOARD_H-1:0] board,
    piece_ctrl_if.master               calc,
    output logic [BITS_PER_BLOCK-1:0]  cur_piece,
    output logic [XW-1:0]              cur_x,
    output logic [YW-1:0]              cur_y,
    output logic [BITS_ROT-1:0]        cur_rot,
    output logic                       busy,
    output logic                       lock_req,
    output logic                       game_over
);
    localparam logic [XW-1:0] SPAWN_X = XW'(BOARD_W/2 - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       pending;
    logic       pending_nxt;
    req_e       req;
    logic       legal;

    logic [BITS_PER_BLOCK-1:0] cand_piece_p1;
    logic [XW-1:0]             cand_x_p1;
    logic [YW-1:0]             cand_y_p1;
    logic [BITS_ROT-1:0]       cand_rot_p1;
    logic                      cand_down_p1;

    logic                      cand_load;
    logic [BITS_PER_BLOCK-1:0] nxt_piece;
    logic [XW-1:0]             nxt_x;
    logic [YW-1:0]             nxt_y;
    logic [BITS_ROT-1:0]       nxt_rot;
    logic                      nxt_down;
    logic                      commit;
    logic                      lock_set;
    logic                      over_set;
    logic                      clear_piece;
`ifdef TETRIS_WALL_KICK_EN
    logic                      cand_isrot_p1;
    logic                      nxt_isrot;
`endif

    assign busy = (state == ST_CHECK) || (state == ST_SPAWN) || (state == ST_KICK);

    // Outside the evaluation states the calculator simply tracks the committed piece.
    assign calc.cand_piece = busy ? cand_piece_p1 : cur_piece;
    assign calc.cand_x     = busy ? cand_x_p1     : cur_x;
    assign calc.cand_y     = busy ? cand_y_p1     : cur_y;
    assign calc.cand_rot   = busy ? cand_rot_p1   : cur_rot;

    blk_collide #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .XW      (XW),
        .YW      (YW),
        .POSW    (POSW)
    ) u_collide (
        .blk_1  (calc.cand_blk_1),
        .blk_2  (calc.cand_blk_2),
        .blk_3  (calc.cand_blk_3),
        .blk_4  (calc.cand_blk_4),
        .width  (calc.cand_width),
        .height (calc.cand_height),
        .cand_x (cand_x_p1),
        .cand_y (cand_y_p1),
        .board  (board),
        .legal  (legal)
    );

    // A pending gravity step outranks every fresh request.
    always_comb begin
        req = REQ_NONE;
        if (pending)                   req = REQ_DOWN;
        else if (mv_rot)               req = REQ_ROT;
        else if (mv_left)              req = REQ_LEFT;
        else if (mv_right)             req = REQ_RIGHT;
        else if (mv_down || gravity_tick) req = REQ_DOWN;
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending | (busy & gravity_tick);
        cand_load   = 1'b0;
        nxt_piece   = cur_piece;
        nxt_x       = cur_x;
        nxt_y       = cur_y;
        nxt_rot     = cur_rot;
        nxt_down    = 1'b0;
        commit      = 1'b0;
        lock_set    = 1'b0;
        over_set    = 1'b0;
        clear_piece = 1'b0;
`ifdef TETRIS_WALL_KICK_EN
        nxt_isrot   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                clear_piece = 1'b1;
                pending_nxt = 1'b0;
                if (spawn) begin
                    cand_load = 1'b1;
                    nxt_piece = spawn_piece;
                    nxt_x     = SPAWN_X;
                    nxt_y     = '0;
                    nxt_rot   = '0;
                    state_nxt = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                if (legal) begin
                    commit    = 1'b1;
                    state_nxt = ST_READY;
                end else begin
                    over_set  = 1'b1;
                    state_nxt = ST_OVER;
                end
            end
            ST_READY: begin
                case (req)
                    REQ_ROT: begin
                        cand_load = 1'b1;
                        nxt_rot   = rot_next(cur_rot);
`ifdef TETRIS_WALL_KICK_EN
                        nxt_isrot = 1'b1;
`endif
                    end
                    REQ_LEFT: begin
                        if (cur_x != '0) begin
                            cand_load = 1'b1;
                            nxt_x     = cur_x - XW'(1);
                        end
                    end
                    REQ_RIGHT: begin
                        cand_load = 1'b1;
                        nxt_x     = cur_x + XW'(1);
                    end
                    REQ_DOWN: begin
                        cand_load   = 1'b1;
                        nxt_y       = cur_y + YW'(1);
                        nxt_down    = 1'b1;
                        pending_nxt = 1'b0;
                    end
                    default: ;
                endcase
                if (cand_load)
                    state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (legal) begin
                    commit    = 1'b1;
                    state_nxt = ST_READY;
                end else if (cand_down_p1) begin
                    lock_set  = 1'b1;
                    state_nxt = ST_IDLE;
`ifdef TETRIS_WALL_KICK_EN
                end else if (cand_isrot_p1 && cur_x != '0) begin
                    cand_load = 1'b1;
                    nxt_piece = cand_piece_p1;
                    nxt_x     = cur_x - XW'(1);
                    nxt_y     = cand_y_p1;
                    nxt_rot   = cand_rot_p1;
                    nxt_isrot = 1'b1;
                    state_nxt = ST_KICK;
`endif
                end else begin
                    state_nxt = ST_READY;
                end
            end
`ifdef TETRIS_WALL_KICK_EN
            ST_KICK: begin
                commit    = legal;
                state_nxt = ST_READY;
            end
`endif
            ST_OVER: begin
                pending_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage p1: registered candidate presented to the calculator.
    always_ff @(posedge clk) begin
        if (cand_load) begin
            cand_piece_p1 <= nxt_piece;
            cand_x_p1     <= nxt_x;
            cand_y_p1     <= nxt_y;
            cand_rot_p1   <= nxt_rot;
            cand_down_p1  <= nxt_down;
`ifdef TETRIS_WALL_KICK_EN
            cand_isrot_p1 <= nxt_isrot;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            pending   <= 1'b0;
            lock_req  <= 1'b0;
            game_over <= 1'b0;
            cur_piece <= PIECE_EMPTY;
            cur_x     <= '0;
            cur_y     <= '0;
            cur_rot   <= '0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            lock_req <= lock_set;
            if (over_set)
                game_over <= 1'b1;
            if (commit) begin
                cur_piece <= cand_piece_p1;
                cur_x     <= cand_x_p1;
                cur_y     <= cand_y_p1;
                cur_rot   <= cand_rot_p1;
            end else if (clear_piece) begin
                cur_piece <= PIECE_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_piece_ctrl.sv
// Bench for piece_ctrl with a behavioural block-position calculator (I, O, T shapes).
// Kick expectations follow TETRIS_WALL_KICK_EN.
`timescale 1ns/1ps
module tb_piece_ctrl;
    import piece_ctrl_pkg::*;

    localparam int BW = 10;
    localparam int BH = 20;
    localparam int XW = 4;
    localparam int YW = 5;
    localparam int POSW = 8;

    localparam logic [2:0] OP_SPAWN = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_DOWN  = 3'd3;
    localparam logic [2:0] OP_ROT   = 3'd4;
    localparam logic [2:0] OP_GRAV  = 3'd5;

    logic clk = 1'b0;
    logic rst;
    logic spawn;
    logic [2:0] spawn_piece;
    logic mv_left, mv_right, mv_down, mv_rot, gravity_tick;
    logic [BW*BH-1:0] board;
    logic [2:0] cur_piece;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [1:0] cur_rot;
    logic busy, lock_req, game_over;

    int checks = 0;
    int errors = 0;

    piece_ctrl_if #(.XW(XW), .YW(YW), .POSW(POSW)) calc();

    piece_ctrl #(.BOARD_W(BW), .BOARD_H(BH), .XW(XW), .YW(YW), .POSW(POSW)) dut (
        .clk(clk), .rst(rst), .spawn(spawn), .spawn_piece(spawn_piece),
        .mv_left(mv_left), .mv_right(mv_right), .mv_down(mv_down), .mv_rot(mv_rot),
        .gravity_tick(gravity_tick), .board(board), .calc(calc),
        .cur_piece(cur_piece), .cur_x(cur_x), .cur_y(cur_y), .cur_rot(cur_rot),
        .busy(busy), .lock_req(lock_req), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Behavioural calculator: per-cell offsets (element 0 first) plus extent.
    typedef struct packed {
        logic [3:0][1:0] dx;
        logic [3:0][1:0] dy;
        logic [2:0]      w;
        logic [2:0]      h;
        logic            ok;
    } shape_t;

    function automatic shape_t shape_of(input logic [2:0] p, input logic [1:0] r);
        shape_t s;
        s = '0;
        s.ok = 1'b1;
        case (p)
            3'd1: if (!r[0]) begin s.dx = {2'd0,2'd0,2'd0,2'd0}; s.dy = {2'd3,2'd2,2'd1,2'd0}; s.w = 3'd1; s.h = 3'd4; end
                  else       begin s.dx = {2'd3,2'd2,2'd1,2'd0}; s.dy = {2'd0,2'd0,2'd0,2'd0}; s.w = 3'd4; s.h = 3'd1; end
            3'd2: begin s.dx = {2'd1,2'd0,2'd1,2'd0}; s.dy = {2'd1,2'd1,2'd0,2'd0}; s.w = 3'd2; s.h = 3'd2; end
            3'd3: case (r)
                2'd0: begin s.dx = {2'd2,2'd1,2'd0,2'd1}; s.dy = {2'd1,2'd1,2'd1,2'd0}; s.w = 3'd3; s.h = 3'd2; end
                2'd1: begin s.dx = {2'd0,2'd1,2'd0,2'd0}; s.dy = {2'd2,2'd1,2'd1,2'd0}; s.w = 3'd2; s.h = 3'd3; end
                2'd2: begin s.dx = {2'd1,2'd2,2'd1,2'd0}; s.dy = {2'd1,2'd0,2'd0,2'd0}; s.w = 3'd3; s.h = 3'd2; end
                default: begin s.dx = {2'd1,2'd1,2'd0,2'd1}; s.dy = {2'd2,2'd1,2'd1,2'd0}; s.w = 3'd2; s.h = 3'd3; end
            endcase
            default: s = '0;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] cell_idx(input logic [3:0] x, input logic [4:0] y,
                                            input logic [1:0] dx, input logic [1:0] dy,
                                            input logic ok);
        int cx, cy;
        cx = int'(x) + int'(dx);
        cy = int'(y) + int'(dy);
        if (!ok || cx >= BW || cy >= BH)
            return 8'hFF;
        return 8'(cy * BW + cx);
    endfunction

    shape_t cs;
    assign cs = shape_of(calc.cand_piece, calc.cand_rot);
    assign calc.cand_blk_1  = cell_idx(calc.cand_x, calc.cand_y, cs.dx[0], cs.dy[0], cs.ok);
    assign calc.cand_blk_2  = cell_idx(calc.cand_x, calc.cand_y, cs.dx[1], cs.dy[1], cs.ok);
    assign calc.cand_blk_3  = cell_idx(calc.cand_x, calc.cand_y, cs.dx[2], cs.dy[2], cs.ok);
    assign calc.cand_blk_4  = cell_idx(calc.cand_x, calc.cand_y, cs.dx[3], cs.dy[3], cs.ok);
    assign calc.cand_width  = cs.w;
    assign calc.cand_height = cs.h;

    typedef struct {
        logic [2:0] op;
        logic [2:0] arg;
        logic [2:0] piece;
        logic [3:0] x;
        logic [4:0] y;
        logic [1:0] rot;
    } vec_t;

    // Observed tuple {piece, x, y, rot, busy, lock_req}.
    typedef logic [15:0] obs_t;
    obs_t exp_q[$];
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        spawn = 1'b0; spawn_piece = 3'd0;
        mv_left = 1'b0; mv_right = 1'b0; mv_down = 1'b0; mv_rot = 1'b0;
        gravity_tick = 1'b0;
    endtask

    // Drives a one-cycle request; returns at the negedge after the sampling edge.
    task automatic pulse(input logic [2:0] op, input logic [2:0] arg);
        case (op)
            OP_SPAWN: begin spawn = 1'b1; spawn_piece = arg; end
            OP_LEFT:  mv_left = 1'b1;
            OP_RIGHT: mv_right = 1'b1;
            OP_DOWN:  mv_down = 1'b1;
            OP_ROT:   mv_rot = 1'b1;
            default:  gravity_tick = 1'b1;
        endcase
        tick(1);
        clear_reqs();
    endtask

    task automatic step(input logic [2:0] op, input logic [2:0] arg);
        pulse(op, arg);
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        board = '0;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        obs_t e;
        exp_q.push_back({v.piece, v.x, v.y, v.rot, 2'b00});
        step(v.op, v.arg);
        e = exp_q.pop_front();
        check($sformatf("vec%0d_cur", idx),
              32'({cur_piece, cur_x, cur_y, cur_rot, busy, lock_req}), 32'(e));
        check($sformatf("vec%0d_cand", idx),
              32'({calc.cand_piece, calc.cand_x, calc.cand_y, calc.cand_rot}), 32'(e[15:2]));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{OP_SPAWN, 3'd3, 3'd3, 4'd4, 5'd0, 2'd0};
        vecs[1] = '{OP_ROT,   3'd0, 3'd3, 4'd4, 5'd0, 2'd1};
        vecs[2] = '{OP_ROT,   3'd0, 3'd3, 4'd4, 5'd0, 2'd2};
        vecs[3] = '{OP_ROT,   3'd0, 3'd3, 4'd4, 5'd0, 2'd3};
        vecs[4] = '{OP_ROT,   3'd0, 3'd3, 4'd4, 5'd0, 2'd0};
        vecs[5] = '{OP_LEFT,  3'd0, 3'd3, 4'd3, 5'd0, 2'd0};
        vecs[6] = '{OP_DOWN,  3'd0, 3'd3, 4'd3, 5'd1, 2'd0};
        vecs[7] = '{OP_GRAV,  3'd0, 3'd3, 4'd3, 5'd2, 2'd0};
        vecs[8] = '{OP_RIGHT, 3'd0, 3'd3, 4'd4, 5'd2, 2'd0};
        vecs[9] = '{OP_LEFT,  3'd0, 3'd3, 4'd3, 5'd2, 2'd0};

        clear_reqs();
        board = '0;
        rst = 1'b1;
        tick(2);
        check("reset_state", 32'({cur_piece, cur_x, cur_y, cur_rot, busy, lock_req, game_over}), 32'd0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], i);

        // T rot0 at (3,2) moving down onto locked cell 44.
        board[44] = 1'b1;
        pulse(OP_DOWN, 3'd0);
        check("col_busy", 32'(busy), 32'd1);
        tick(1);
        check("col_lock", 32'({lock_req, cur_piece, cur_x, cur_y}), 32'({1'b1, 3'd3, 4'd3, 5'd2}));
        tick(1);
        check("col_idle", 32'({lock_req, cur_piece, busy}), 32'({1'b0, 3'd0, 1'b0}));

        // O piece against both side walls.
        do_reset();
        step(OP_SPAWN, 3'd2);
        for (int i = 0; i < 4; i++) step(OP_LEFT, 3'd0);
        check("o_at_left", 32'(cur_x), 32'd0);
        pulse(OP_LEFT, 3'd0);
        check("left_x0_nobusy", 32'(busy), 32'd0);
        tick(1);
        check("left_x0_hold", 32'(cur_x), 32'd0);
        for (int i = 0; i < 8; i++) step(OP_RIGHT, 3'd0);
        check("o_at_x8", 32'(cur_x), 32'd8);
        pulse(OP_RIGHT, 3'd0);
        check("right_wall_busy", 32'(busy), 32'd1);
        tick(1);
        check("right_wall_hold", 32'({cur_x, busy}), 32'({4'd8, 1'b0}));

        // Vertical I dropped to the floor by gravity.
        do_reset();
        step(OP_SPAWN, 3'd1);
        for (int i = 0; i < 16; i++) step(OP_DOWN, 3'd0);
        check("i_at_y16", 32'({cur_piece, cur_y}), 32'({3'd1, 5'd16}));
        pulse(OP_GRAV, 3'd0);
        tick(1);
        check("floor_lock", 32'({lock_req, cur_piece, cur_y}), 32'({1'b1, 3'd1, 5'd16}));
        tick(1);
        check("floor_cleared", 32'({lock_req, cur_piece}), 32'd0);
        step(OP_DOWN, 3'd0);
        check("idle_ignores_down", 32'({cur_piece, busy}), 32'd0);

        // Gravity arriving during CHECK is held and serviced afterwards.
        do_reset();
        step(OP_SPAWN, 3'd3);
        mv_rot = 1'b1;
        tick(1);
        mv_rot = 1'b0;
        gravity_tick = 1'b1;
        check("pend_in_check", 32'(busy), 32'd1);
        tick(1);
        gravity_tick = 1'b0;
        check("pend_rot_commit", 32'({cur_rot, cur_y}), 32'({2'd1, 5'd0}));
        tick(1);
        check("pend_check_again", 32'(busy), 32'd1);
        tick(1);
        check("pend_down_commit", 32'({cur_rot, cur_y, busy}), 32'({2'd1, 5'd1, 1'b0}));

        // Blocked spawn ends the game until reset.
        do_reset();
        board[5] = 1'b1;
        step(OP_SPAWN, 3'd3);
        check("spawn_blocked", 32'({game_over, cur_piece, busy}), 32'({1'b1, 3'd0, 1'b0}));
        board = '0;
        step(OP_SPAWN, 3'd3);
        step(OP_DOWN, 3'd0);
        check("over_holds", 32'({game_over, cur_piece, busy}), 32'({1'b1, 3'd0, 1'b0}));
        do_reset();
        check("over_cleared", 32'(game_over), 32'd0);
        step(OP_SPAWN, 3'd3);
        check("respawn_ok", 32'({cur_piece, cur_x}), 32'({3'd3, 4'd4}));

        // Rotation blocked by the right wall.
        do_reset();
        step(OP_SPAWN, 3'd3);
        step(OP_ROT, 3'd0);
        for (int i = 0; i < 4; i++) step(OP_RIGHT, 3'd0);
        check("t_rot1_x8", 32'({cur_x, cur_rot}), 32'({4'd8, 2'd1}));
        pulse(OP_ROT, 3'd0);
        tick(1);
`ifdef TETRIS_WALL_KICK_EN
        check("kick_busy", 32'({busy, cur_x, cur_rot}), 32'({1'b1, 4'd8, 2'd1}));
        tick(1);
        check("kick_commit", 32'({busy, cur_x, cur_rot}), 32'({1'b0, 4'd7, 2'd2}));
`else
        check("rot_rejected", 32'({busy, cur_x, cur_rot}), 32'({1'b0, 4'd8, 2'd1}));
`endif

        // Reset asserted while a locking move is in CHECK.
        do_reset();
        step(OP_SPAWN, 3'd3);
        board[25] = 1'b1;
        pulse(OP_DOWN, 3'd0);
        check("rst_mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_state", 32'({cur_piece, cur_x, busy, lock_req}), 32'd0);
        tick(1);
        rst = 1'b0;
        board = '0;
        tick(2);
        check("rst_mid_nolock", 32'({lock_req, cur_piece, busy}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
